// File: rtl/seqdet_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seqdet_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_PLEN_MAX = 4;

  // Sequencer states; encodings are fixed so they match existing tooling.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/seqdet_match.sv
// Overlapping pattern matcher: keeps a bit history and a saturating fill
// count, and flags when the newest len bits equal the programmed pattern.
module seqdet_match import seqdet_pkg::*; #(
  parameter int unsigned PLEN_MAX = DEF_PLEN_MAX,
  parameter int unsigned LEN_W    = $clog2(PLEN_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                bit_i,
  input  logic [PLEN_MAX-1:0] pat_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic                clr_i,
  output logic                match_o
);

  logic [PLEN_MAX-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]    fill_q, fill_d;
  logic [PLEN_MAX-1:0] mask;

  // Next history/fill and the match decision for the bit being consumed now.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PLEN_MAX; i++) begin
      mask[i] = (LEN_W'(i) < len_i);
    end
    hist_d  = PLEN_MAX'({hist_q, bit_i});
    fill_d  = (fill_q == LEN_W'(PLEN_MAX)) ? fill_q : fill_q + 1'b1;
    // pat[len-1] lines up with the oldest history bit, pat[0] with the newest
    match_o = en_i && (len_i != '0) && (fill_d >= len_i) &&
              (((hist_d ^ pat_i) & mask) == '0);
  end

  // History persists across words; only reset or a config write clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (en_i) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seqdet_ctrl.sv
// Word-level sequencer: accepts words, serialises them MSB first into the
// matcher and returns a per-word match count / first-match index.
module seqdet_ctrl import seqdet_pkg::*; #(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PLEN_MAX = DEF_PLEN_MAX,
  parameter int unsigned CNT_W    = $clog2(WIDTH + 1),
  parameter int unsigned LEN_W    = $clog2(PLEN_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [PLEN_MAX-1:0] cfg_pat,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    out_count,
  output logic [CNT_W-1:0]    out_first,
  output logic                out_hit,
  output logic                det_pulse,
  output logic                ser_bit,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    first_q, first_d;
  logic                hit_q, hit_d;
  logic                out_valid_q, out_valid_d;
  logic                det_pulse_q, det_pulse_d;
  logic                ser_bit_q, ser_bit_d;
  logic [PLEN_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                match_en, match_clr, match;

  assign match_en  = (state_q == StShift);
  assign match_clr = (state_q == StIdle) && cfg_we;

  seqdet_match #(
    .PLEN_MAX (PLEN_MAX),
    .LEN_W    (LEN_W)
  ) u_match (
    .clk     (clk),
    .rst     (rst),
    .en_i    (match_en),
    .bit_i   (shreg_q[WIDTH-1]),
    .pat_i   (pat_q),
    .len_i   (len_q),
    .clr_i   (match_clr),
    .match_o (match)
  );

  // Config write takes priority, so input is refused in that cycle.
  assign in_ready  = rst && (state_q == StIdle) && !cfg_we;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_count = count_q;
  assign out_first = first_q;
  assign out_hit   = hit_q;
  assign det_pulse = det_pulse_q;
  assign ser_bit   = ser_bit_q;

  // Next-state: FSM, shifter, result accumulation and config latch.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    count_d     = count_q;
    first_d     = first_q;
    hit_d       = hit_q;
    out_valid_d = out_valid_q;
    det_pulse_d = 1'b0;
    ser_bit_d   = ser_bit_q;
    pat_d       = pat_q;
    len_d       = len_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_we) begin
          pat_d = cfg_pat;
          len_d = (cfg_len > LEN_W'(PLEN_MAX)) ? LEN_W'(PLEN_MAX) : cfg_len;
        end else if (in_valid) begin
          shreg_d = in_data;
          idx_d   = '0;
          count_d = '0;
          first_d = '0;
          hit_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        ser_bit_d = shreg_q[WIDTH-1];
        idx_d     = idx_q + 1'b1;
        if (match) begin
          det_pulse_d = 1'b1;
          count_d     = count_q + 1'b1;
          if (count_q == '0) begin
            first_d = idx_q;
            hit_d   = 1'b1;
          end
        end
        if (idx_q == CNT_W'(WIDTH - 1)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      first_q     <= '0;
      hit_q       <= 1'b0;
      out_valid_q <= 1'b0;
      det_pulse_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      pat_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      first_q     <= first_d;
      hit_q       <= hit_d;
      out_valid_q <= out_valid_d;
      det_pulse_q <= det_pulse_d;
      ser_bit_q   <= ser_bit_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
    end
  end

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Bench for seqdet_ctrl: directed scenarios plus random words, checked
// against a bit-history reference model.
module tb_seqdet_ctrl;

  localparam int WIDTH    = 8;
  localparam int PLEN_MAX = 4;
  localparam int CNT_W    = 4;
  localparam int LEN_W    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [3:0]       cfg_pat = '0;
  logic [2:0]       cfg_len = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_first;
  logic             out_hit;
  logic             det_pulse;
  logic             ser_bit;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: all bits consumed since the last clear.
  bit         mq[$];
  logic [3:0] m_pat = '0;
  int         m_len = 0;

  always #5 clk = ~clk;

  seqdet_ctrl #(
    .WIDTH    (WIDTH),
    .PLEN_MAX (PLEN_MAX),
    .CNT_W    (CNT_W),
    .LEN_W    (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_first (out_first),
    .out_hit   (out_hit),
    .det_pulse (det_pulse),
    .ser_bit   (ser_bit),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Push the word's bits through the history, counting every overlapping match.
  task automatic model_word(input logic [7:0] w, output int cnt, output int first,
                            output logic [7:0] pulses);
    cnt    = 0;
    first  = 0;
    pulses = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bit ok;
      mq.push_back(w[WIDTH-1-i]);
      if (mq.size() > PLEN_MAX) void'(mq.pop_front());
      ok = (m_len > 0) && (mq.size() >= m_len);
      for (int k = 0; k < m_len; k++) begin
        if (ok && (mq[mq.size()-1-k] != m_pat[k])) ok = 0;
      end
      if (ok) begin
        pulses[i] = 1'b1;
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endtask

  task automatic do_cfg(input logic [3:0] p, input int l, input bit with_valid);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_pat  = p;
    cfg_len  = 3'(l);
    in_valid = with_valid;
    in_data  = 8'hFF;
    #1;
    check("cfg_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    check("cfg_busy", busy, 0);
    m_pat = p;
    m_len = (l > PLEN_MAX) ? PLEN_MAX : l;
    mq.delete();
  endtask

  task automatic send_word(input logic [7:0] w, input int hold, input bit cfg_mid);
    int         cnt, first;
    logic [7:0] pl;
    model_word(w, cnt, first, pl);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    #1;
    check("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    check("busy_after_accept", busy, 1);
    for (int i = 0; i < WIDTH; i++) begin
      if (cfg_mid && i == 2) begin
        cfg_we  = 1'b1;
        cfg_pat = ~m_pat;
        cfg_len = 3'd1;
      end
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      check($sformatf("det_pulse[%0d]", i), det_pulse, pl[i]);
      check($sformatf("ser_bit[%0d]", i), ser_bit, w[WIDTH-1-i]);
      check($sformatf("out_valid[%0d]", i), out_valid, (i == WIDTH - 1));
    end
    check("out_count", out_count, cnt);
    check("out_first", out_first, first);
    check("out_hit", out_hit, (cnt != 0));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_count", out_count, cnt);
      check("hold_first", out_first, first);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("done_valid_low", out_valid, 0);
    check("done_busy_low", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_det", det_pulse, 0);
    @(negedge clk);
    rst = 1'b1;

    // Overlapping matches within one word.
    do_cfg(4'b1011, 4, 1'b1);
    send_word(8'b1011_0110, 0, 1'b0);
    check("t1_count", out_count, 2);
    check("t1_first", out_first, 3);

    // Match spanning a word boundary, with a held result.
    send_word(8'b0000_0101, 5, 1'b0);
    send_word(8'b1000_0000, 0, 1'b0);
    check("t2_count", out_count, 1);
    check("t2_first", out_first, 0);

    // Reset three bits into a word.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'b1011_0110;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_ser", ser_bit, 0);
    check("mid_rst_in_ready", in_ready, 0);
    mq.delete();
    m_pat = '0;
    m_len = 0;
    @(negedge clk);
    rst = 1'b1;
    send_word(8'hFF, 0, 1'b0);
    check("post_rst_len0", out_count, 0);
    do_cfg(4'b1011, 4, 1'b0);
    send_word(8'b1011_0000, 1, 1'b0);
    check("t4_count", out_count, 1);
    check("t4_first", out_first, 3);

    // Config ignored mid-word; disabled detector; single-bit pattern.
    send_word(8'hAA, 0, 1'b1);
    do_cfg(4'b0000, 0, 1'b0);
    send_word(8'hFF, 0, 1'b0);
    check("t5_len0_hit", out_hit, 0);
    do_cfg(4'b0001, 1, 1'b0);
    send_word(8'hFF, 0, 1'b0);
    check("t5_count8", out_count, 8);
    check("t5_first0", out_first, 0);

    // Config rewrite clears history.
    do_cfg(4'b1011, 4, 1'b0);
    send_word(8'b0000_0101, 0, 1'b0);
    do_cfg(4'b1011, 4, 1'b0);
    send_word(8'b1000_0000, 0, 1'b0);
    check("t6_count", out_count, 0);

    // Over-length config clamps to the maximum.
    do_cfg(4'b0110, 7, 1'b0);
    send_word(8'b0110_1101, 0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_cfg(4'($urandom), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      send_word(8'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
